// File: rtl/vga_pixel_fetch_pkg.sv
// -----------------------------------------------------------------------------
// vga_pixel_fetch_pkg
// Shared definitions for the VGA pixel fetch block: default geometry, coordinate
// and colour widths, FSM state encodings, the layout of the aligned-control
// delay tap and the RGB field positions inside the 24-bit palette word.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pixel_fetch_pkg;

  localparam int DEF_H_ACTIVE  = 800;
  localparam int DEF_V_ACTIVE  = 600;
  localparam int DEF_ADDR_W    = 19;
  localparam int DEF_FETCH_LAT = 2;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 24;

  // Two-state lock FSM, kept as plain constants for older tool flows.
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  // Palette word is {R,G,B}.
  localparam int RED_LSB   = 16;
  localparam int GREEN_LSB = 8;
  localparam int BLUE_LSB  = 0;

  // Control bits that travel together through the latency-matching delay line.
  typedef struct packed {
    logic frame_start;
    logic blank_n;
    logic hs;
    logic vs;
  } tap_t;

  // Idle values: no frame start, blanked, syncs de-asserted (high).
  localparam tap_t TAP_RESET = '{frame_start: 1'b0, blank_n: 1'b0, hs: 1'b1, vs: 1'b1};

  function automatic logic [7:0] rgb_field(input logic [RGB_W-1:0] rgb, input int lsb);
    return rgb[lsb +: 8];
  endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// -----------------------------------------------------------------------------
// vga_pixel_fetch_if
// Bundles the sync-generator inputs, the framebuffer/palette read path and the
// aligned DAC-side outputs of the pixel fetch block.
//   slave  : the pixel fetch block's view (takes sync + rgb_in, drives the rest)
//   master : the surrounding system's view (sync generator, RAMs, DAC)
// Signals: in_blank_n, in_hs, in_vs, in_pixel_h, in_pixel_v, mem_addr,
//          mem_rd_en, rgb_in, blank_n, HS, VS, red, green, blue, frame_start,
//          sync_err, err_cnt.
// -----------------------------------------------------------------------------
interface vga_pixel_fetch_if
  import vga_pixel_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic               in_blank_n;
  logic               in_hs;
  logic               in_vs;
  logic [COORD_W-1:0] in_pixel_h;
  logic [COORD_W-1:0] in_pixel_v;

  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd_en;
  logic [RGB_W-1:0]   rgb_in;

  logic               blank_n;
  logic               HS;
  logic               VS;
  logic [7:0]         red;
  logic [7:0]         green;
  logic [7:0]         blue;
  logic               frame_start;
  logic               sync_err;
  logic [7:0]         err_cnt;

  modport slave (
    input  in_blank_n, in_hs, in_vs, in_pixel_h, in_pixel_v, rgb_in,
    output mem_addr, mem_rd_en, blank_n, HS, VS, red, green, blue,
           frame_start, sync_err, err_cnt
  );

  modport master (
    output in_blank_n, in_hs, in_vs, in_pixel_h, in_pixel_v, rgb_in,
    input  mem_addr, mem_rd_en, blank_n, HS, VS, red, green, blue,
           frame_start, sync_err, err_cnt
  );

endinterface

// File: rtl/vga_pixel_fetch_delay_line.sv
// -----------------------------------------------------------------------------
// vga_pixel_fetch_delay_line
// Fixed-depth shift register; reset loads every stage with RESET_VAL so the
// output shows idle values until real data has travelled the full depth.
// Ports:
//   clk    in   1      clock
//   reset  in   1      synchronous, active-high flush
//   din    in   WIDTH  data entering stage 0
//   dout   out  WIDTH  data leaving the last stage, DEPTH cycles later
// -----------------------------------------------------------------------------
module vga_pixel_fetch_delay_line #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift one stage per clock; reset flushes the whole line at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= RESET_VAL;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// -----------------------------------------------------------------------------
// vga_pixel_fetch
// Turns the sync generator's next-pixel coordinates into framebuffer read
// addresses without a multiplier (row base advances by H_ACTIVE per line,
// column by one per pixel), delays HS/VS/blank_n to line up with the palette
// output, and registers the colour for the DAC. A coordinate sequence that
// disagrees with the internal counters drops the lock; the next frame origin
// re-acquires it.
// Ports:
//   vga_clk  in  1   pixel clock
//   reset    in  1   synchronous, active-high
//   bus      vga_pixel_fetch_if.slave
//            in_blank_n/in_hs/in_vs/in_pixel_h/in_pixel_v  from sync generator
//            mem_addr/mem_rd_en -> framebuffer, rgb_in <- palette
//            blank_n/HS/VS/red/green/blue/frame_start      aligned to DAC
//            sync_err (sticky), err_cnt (saturating)       status
// -----------------------------------------------------------------------------
module vga_pixel_fetch
  import vga_pixel_fetch_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FETCH_LAT = DEF_FETCH_LAT
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_pixel_fetch_if.slave bus
);

  // One cycle for the address register, FETCH_LAT through RAM + palette, one
  // for the colour register.
  localparam int                 LAT     = FETCH_LAT + 2;
  localparam logic [ADDR_W-1:0]  STRIDE  = ADDR_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] H_LIMIT = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIMIT = COORD_W'(V_ACTIVE);

  logic [0:0]         state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  row_base_q;
  logic [COORD_W-1:0] col_q;
  logic [COORD_W-1:0] line_q;
  logic               rd_en_q;
  logic               sync_err_q;
  logic [7:0]         err_cnt_q;
  logic [RGB_W-1:0]   rgb_q;

  logic vis;
  logic origin;
  logic locked;
  logic mismatch;
  logic fetch;
  tap_t tap_in;
  tap_t tap_out;

  // Classify the incoming pixel. col_q is the column expected next and line_q
  // the row currently being fetched, so a new line must arrive as h==0 with
  // v one past line_q. Coordinates outside the active area are treated as a
  // discontinuity, which also keeps mem_addr inside the framebuffer. The origin
  // always wins so a broken frame can never block re-locking.
  always_comb begin
    vis      = bus.in_blank_n;
    origin   = vis && (bus.in_pixel_h == '0) && (bus.in_pixel_v == '0);
    locked   = (state_q == ST_LOCKED);
    mismatch = 1'b0;
    if (locked && vis && !origin) begin
      if ((bus.in_pixel_h >= H_LIMIT) || (bus.in_pixel_v >= V_LIMIT)) begin
        mismatch = 1'b1;
      end else if (bus.in_pixel_h == '0) begin
        mismatch = (bus.in_pixel_v != (line_q + COORD_W'(1)));
      end else begin
        mismatch = (bus.in_pixel_h != col_q);
      end
    end
    fetch = origin || (locked && vis && !mismatch);

    // The delayed blank is the fetch itself, so blank_n only rises on pixels
    // whose colour really came out of the framebuffer.
    tap_in.frame_start = origin;
    tap_in.blank_n     = fetch;
    tap_in.hs          = bus.in_hs;
    tap_in.vs          = bus.in_vs;
  end

  // Lock FSM, address generation and error bookkeeping. mem_addr simply holds
  // whenever nothing is fetched (blanking, unlocked, or a mismatch cycle).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      addr_q     <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      line_q     <= '0;
      rd_en_q    <= 1'b0;
      sync_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      rd_en_q <= fetch;
      if (origin) begin
        state_q    <= ST_LOCKED;
        addr_q     <= '0;
        row_base_q <= '0;
        line_q     <= '0;
        col_q      <= COORD_W'(1);
      end else if (mismatch) begin
        state_q    <= ST_UNLOCKED;
        sync_err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end else if (fetch) begin
        if (bus.in_pixel_h == '0) begin
          addr_q     <= row_base_q + STRIDE;
          row_base_q <= row_base_q + STRIDE;
          line_q     <= line_q + COORD_W'(1);
          col_q      <= COORD_W'(1);
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
          col_q  <= col_q + COORD_W'(1);
        end
      end
    end
  end

  // Palette output register; the colour is gated by the aligned blank below so
  // stale palette data never leaks out during blanking or while unlocked.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= bus.rgb_in;
    end
  end

  vga_pixel_fetch_delay_line #(
    .WIDTH     ($bits(tap_t)),
    .DEPTH     (LAT),
    .RESET_VAL (TAP_RESET)
  ) u_delay (
    .clk   (vga_clk),
    .reset (reset),
    .din   (tap_in),
    .dout  (tap_out)
  );

  assign bus.mem_addr    = addr_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.blank_n     = tap_out.blank_n;
  assign bus.HS          = tap_out.hs;
  assign bus.VS          = tap_out.vs;
  assign bus.frame_start = tap_out.frame_start;
  assign bus.red         = tap_out.blank_n ? rgb_field(rgb_q, RED_LSB)   : 8'd0;
  assign bus.green       = tap_out.blank_n ? rgb_field(rgb_q, GREEN_LSB) : 8'd0;
  assign bus.blue        = tap_out.blank_n ? rgb_field(rgb_q, BLUE_LSB)  : 8'd0;
  assign bus.sync_err    = sync_err_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule
